// File: rtl/picoblaze_interrupt_controller_pkg.sv
// Shared definitions for the PicoBlaze I/O blocks: FSM states, port-ID
// defaults, id width, and the packing of the status word.
package picoblaze_io_pkg;

  localparam int ID_W    = 3;
  localparam int MAX_SRC = 8;

  localparam logic [7:0] DEF_PORT_ID_STAT = 8'h01;
  localparam logic [7:0] DEF_PORT_ID_PEND = 8'h02;
  localparam logic [7:0] DEF_PORT_ID_MASK = 8'h40;
  localparam logic [7:0] DEF_PORT_ID_EOI  = 8'h41;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  function automatic logic [7:0] stat_word(input logic valid, input logic [ID_W-1:0] id);
    return {valid, 4'b0000, id};
  endfunction

endpackage

// File: rtl/picoblaze_interrupt_controller_if.sv
// Processor-side port bus plus the interrupt handshake of the controller.
interface picoblaze_interrupt_controller_if;

  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic       interrupt_ack;
  logic       interrupt;
  logic [7:0] rd_data;
  logic       rd_hit;

  modport master (
    output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    input  interrupt, rd_data, rd_hit
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    output interrupt, rd_data, rd_hit
  );

endinterface

// File: rtl/picoblaze_interrupt_controller_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above i_ptr,
// wrapping from NUM_SRC-1 back to 0.
module rr_arbiter
  import picoblaze_io_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_any_grant
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SRC - 1);

  logic [MAX_SRC-1:0] w_req8;
  logic [ID_W-1:0]    w_idx;

  // Walk NUM_SRC positions from the pointer; explicit wrap keeps odd sizes correct.
  always_comb begin
    w_req8              = 8'h00;
    w_req8[NUM_SRC-1:0] = i_req;
    w_idx               = i_ptr;
    o_grant_id          = 3'd0;
    o_any_grant         = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!o_any_grant && w_req8[w_idx]) begin
        o_any_grant = 1'b1;
        o_grant_id  = w_idx;
      end else begin
        o_any_grant = o_any_grant;
      end
      if (w_idx == LAST_ID) begin
        w_idx = 3'd0;
      end else begin
        w_idx = w_idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/picoblaze_interrupt_controller.sv
// Multiplexes up to 8 event sources onto the single PicoBlaze interrupt line,
// with pending/mask registers, round-robin grant and firmware EOI.
module picoblaze_interrupt_controller
  import picoblaze_io_pkg::*;
#(
  parameter int         NUM_SRC      = 4,
  parameter logic [7:0] PORT_ID_STAT = DEF_PORT_ID_STAT,
  parameter logic [7:0] PORT_ID_PEND = DEF_PORT_ID_PEND,
  parameter logic [7:0] PORT_ID_MASK = DEF_PORT_ID_MASK,
  parameter logic [7:0] PORT_ID_EOI  = DEF_PORT_ID_EOI
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_SRC-1:0]  src_event,
  picoblaze_interrupt_controller_if.slave bus
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SRC - 1);

  irq_state_e          r_state;
  irq_state_e          w_state_nxt;
  logic [NUM_SRC-1:0]  r_pending;
  logic [NUM_SRC-1:0]  r_mask;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_grant_id;
  logic [ID_W-1:0]     r_active_id;
  logic                r_active_valid;
  logic                r_interrupt;
  logic [7:0]          r_rd_data;
  logic                r_rd_hit;

  logic [NUM_SRC-1:0]  w_eligible;
  logic [ID_W-1:0]     w_arb_id;
  logic                w_arb_any;
  logic                w_eoi_wr;
  logic                w_mask_wr;
  logic                w_interrupt_nxt;
  logic                w_latch_grant;
  logic                w_take_ack;
  logic                w_eoi_fire;
  logic [MAX_SRC-1:0]  w_clr8;
  logic [MAX_SRC-1:0]  w_pend8;
  logic [7:0]          w_rd_data;
  logic                w_rd_hit;

  assign w_eligible = r_pending & r_mask;
  assign w_eoi_wr   = bus.write_strobe && (bus.port_id == PORT_ID_EOI);
  assign w_mask_wr  = bus.write_strobe && (bus.port_id == PORT_ID_MASK);

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .i_req       (w_eligible),
    .i_ptr       (r_rr_ptr),
    .o_grant_id  (w_arb_id),
    .o_any_grant (w_arb_any)
  );

  // State register, with the interrupt line registered alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_interrupt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_interrupt <= w_interrupt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_arb_any) w_state_nxt = ASSERT;
        else           w_state_nxt = IDLE;
      end
      ASSERT: begin
        if (bus.interrupt_ack) w_state_nxt = SERVICE;
        else                   w_state_nxt = ASSERT;
      end
      SERVICE: begin
        if (w_eoi_wr) w_state_nxt = IDLE;
        else          w_state_nxt = SERVICE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-state actions feeding the datapath registers.
  always_comb begin
    w_interrupt_nxt = 1'b0;
    w_latch_grant   = 1'b0;
    w_take_ack      = 1'b0;
    w_eoi_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        w_latch_grant   = w_arb_any;
        w_interrupt_nxt = w_arb_any;
      end
      ASSERT: begin
        w_take_ack      = bus.interrupt_ack;
        w_interrupt_nxt = !bus.interrupt_ack;
      end
      SERVICE: begin
        w_eoi_fire = w_eoi_wr;
      end
      default: begin
        w_interrupt_nxt = 1'b0;
      end
    endcase
  end

  // Pending clear mask for EOI; a same-edge event re-sets the bit below.
  always_comb begin
    w_clr8 = 8'h00;
    if (w_eoi_fire) w_clr8[r_active_id] = 1'b1;
    else            w_clr8 = 8'h00;
  end

  // Pending, mask, grant, active source and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending      <= '0;
      r_mask         <= '0;
      r_rr_ptr       <= 3'd0;
      r_grant_id     <= 3'd0;
      r_active_id    <= 3'd0;
      r_active_valid <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr8[NUM_SRC-1:0]) | src_event;
      if (w_mask_wr) r_mask <= bus.out_port[NUM_SRC-1:0];
      if (w_latch_grant) r_grant_id <= w_arb_id;
      if (w_take_ack) begin
        r_active_id    <= r_grant_id;
        r_active_valid <= 1'b1;
      end else if (w_eoi_fire) begin
        r_active_id    <= 3'd0;
        r_active_valid <= 1'b0;
        r_rr_ptr       <= (r_active_id == LAST_ID) ? 3'd0 : r_active_id + 3'd1;
      end
    end
  end

  // Read-port decode.
  always_comb begin
    w_pend8              = 8'h00;
    w_pend8[NUM_SRC-1:0] = r_pending;
    w_rd_hit             = (bus.port_id == PORT_ID_STAT) || (bus.port_id == PORT_ID_PEND);
    if (bus.port_id == PORT_ID_STAT)      w_rd_data = stat_word(r_active_valid, r_active_id);
    else if (bus.port_id == PORT_ID_PEND) w_rd_data = w_pend8;
    else                                  w_rd_data = 8'h00;
  end

  // One-cycle read pipeline matching the registered in_port mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= 8'h00;
      r_rd_hit  <= 1'b0;
    end else begin
      r_rd_data <= w_rd_data;
      r_rd_hit  <= w_rd_hit;
    end
  end

  assign bus.interrupt = r_interrupt;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_hit    = r_rd_hit;

endmodule

// File: tb/tb_picoblaze_interrupt_controller.sv
// Directed bench for the interrupt controller: a cycle-level reference model
// checked every negedge, plus hand-computed checkpoints.
module tb_picoblaze_interrupt_controller;

  localparam int NUM_SRC = 4;
  localparam logic [7:0] P_STAT = 8'h01;
  localparam logic [7:0] P_PEND = 8'h02;
  localparam logic [7:0] P_MASK = 8'h40;
  localparam logic [7:0] P_EOI  = 8'h41;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NUM_SRC-1:0] src_event = '0;
  int                 n_pass = 0;
  int                 n_total = 0;

  picoblaze_interrupt_controller_if bus ();

  picoblaze_interrupt_controller #(.NUM_SRC(NUM_SRC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .src_event (src_event),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending set, masked round-robin selection, one source in service.
  logic [7:0] m_pend, m_mask;
  int         m_ptr, m_grant, m_active;
  logic       m_valid, m_requesting, m_servicing;
  logic       m_irq, m_rd_hit;
  logic [7:0] m_rd_data;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = 8'h00; m_mask = 8'h00; m_ptr = 0; m_grant = 0; m_active = 0;
      m_valid = 1'b0; m_requesting = 1'b0; m_servicing = 1'b0;
      m_irq = 1'b0; m_rd_hit = 1'b0; m_rd_data = 8'h00;
    end else begin
      automatic logic [7:0] elig = m_pend & m_mask;
      automatic logic [7:0] stat = m_valid ? (8'h80 | 8'(m_active)) : 8'h00;
      automatic logic [7:0] pend_old = m_pend;
      automatic logic eoi = bus.write_strobe && bus.port_id == P_EOI;
      m_rd_hit  = (bus.port_id == P_STAT) || (bus.port_id == P_PEND);
      m_rd_data = (bus.port_id == P_STAT) ? stat : (bus.port_id == P_PEND) ? pend_old : 8'h00;
      if (m_servicing) begin
        if (eoi) begin
          m_pend[m_active] = 1'b0;
          m_ptr = (m_active + 1) % NUM_SRC;
          m_valid = 1'b0;
          m_servicing = 1'b0;
        end
      end else if (m_requesting) begin
        if (bus.interrupt_ack) begin
          m_active = m_grant; m_valid = 1'b1;
          m_requesting = 1'b0; m_servicing = 1'b1; m_irq = 1'b0;
        end
      end else begin
        for (int k = 0; k < NUM_SRC; k++) begin
          automatic int i = (m_ptr + k) % NUM_SRC;
          if (!m_requesting && elig[i]) begin
            m_grant = i; m_requesting = 1'b1; m_irq = 1'b1;
          end
        end
      end
      m_pend = m_pend | 8'(src_event);
      if (bus.write_strobe && bus.port_id == P_MASK)
        m_mask = bus.out_port & 8'((1 << NUM_SRC) - 1);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_irq", 8'(bus.interrupt), 8'(m_irq));
    chk("model_rd_hit", 8'(bus.rd_hit), 8'(m_rd_hit));
    chk("model_rd_data", bus.rd_data, m_rd_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.port_id = 8'h00; bus.write_strobe = 1'b0; bus.read_strobe = 1'b0;
    bus.out_port = 8'h00; bus.interrupt_ack = 1'b0; src_event = '0;
  endtask

  task automatic apply_reset();
    idle_bus();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] data);
    bus.port_id = port; bus.out_port = data; bus.write_strobe = 1'b1;
    step();
    bus.write_strobe = 1'b0; bus.port_id = 8'h00; bus.out_port = 8'h00;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] ev);
    src_event = ev;
    step();
    src_event = '0;
  endtask

  task automatic ack();
    bus.interrupt_ack = 1'b1;
    step();
    bus.interrupt_ack = 1'b0;
  endtask

  task automatic rd(input logic [7:0] port, output logic [7:0] data);
    bus.port_id = port; bus.read_strobe = 1'b1;
    step();
    data = bus.rd_data;
    bus.read_strobe = 1'b0; bus.port_id = 8'h00;
  endtask

  task automatic wait_irq(input string name, input int max);
    int n = 0;
    while (bus.interrupt !== 1'b1 && n < max) begin
      step();
      n++;
    end
    chk(name, 8'(bus.interrupt), 8'h01);
  endtask

  logic [7:0] d;
  logic [7:0] order [3] = '{8'h80, 8'h81, 8'h83};

  initial begin
    idle_bus();
    apply_reset();
    chk("reset_irq", 8'(bus.interrupt), 8'h00);
    chk("reset_rd_hit", 8'(bus.rd_hit), 8'h00);
    chk("reset_rd_data", bus.rd_data, 8'h00);

    // 1: single source, latency and status
    wr(P_MASK, 8'h0F);
    pulse(4'b0100);
    chk("t1_irq_n1", 8'(bus.interrupt), 8'h00);
    step();
    chk("t1_irq_n2", 8'(bus.interrupt), 8'h01);
    ack();
    chk("t1_irq_after_ack", 8'(bus.interrupt), 8'h00);
    rd(P_STAT, d); chk("t1_stat", d, 8'h82);
    wr(P_EOI, 8'hA5);
    rd(P_PEND, d); chk("t1_pend_clr", d, 8'h00);
    rd(P_STAT, d); chk("t1_stat_clr", d, 8'h00);

    // 2: round-robin order 0,1,3, pointer back at 0
    apply_reset();
    wr(P_MASK, 8'h0F);
    pulse(4'b1011);
    for (int j = 0; j < 3; j++) begin
      wait_irq("t2_irq", 10);
      ack();
      rd(P_STAT, d); chk("t2_order", d, order[j]);
      wr(P_EOI, 8'h00);
    end
    pulse(4'b1001);
    wait_irq("t2_irq_ptr", 10);
    ack();
    rd(P_STAT, d); chk("t2_ptr_wrap", d, 8'h80);
    wr(P_EOI, 8'h00);
    wait_irq("t2_irq_last", 10);
    ack();
    rd(P_STAT, d); chk("t2_last", d, 8'h83);
    wr(P_EOI, 8'h00);

    // 3: masked source latches, unmask raises interrupt next cycle
    apply_reset();
    wr(P_MASK, 8'h01);
    pulse(4'b0100);
    step(); step(); step();
    chk("t3_masked_irq", 8'(bus.interrupt), 8'h00);
    rd(P_PEND, d); chk("t3_pend", d, 8'h04);
    wr(P_MASK, 8'h04);
    chk("t3_irq_at_write", 8'(bus.interrupt), 8'h00);
    step();
    chk("t3_irq_after", 8'(bus.interrupt), 8'h01);
    ack();
    rd(P_STAT, d); chk("t3_stat", d, 8'h82);
    wr(P_EOI, 8'h00);

    // 4: event on the EOI edge is kept and serviced again
    apply_reset();
    wr(P_MASK, 8'h0F);
    pulse(4'b0010);
    wait_irq("t4_irq", 10);
    ack();
    rd(P_STAT, d); chk("t4_stat", d, 8'h81);
    bus.port_id = P_EOI; bus.write_strobe = 1'b1; src_event = 4'b0010;
    step();
    idle_bus();
    rd(P_PEND, d); chk("t4_pend_kept", d, 8'h02);
    chk("t4_reassert", 8'(bus.interrupt), 8'h01);
    ack();
    rd(P_STAT, d); chk("t4_stat_again", d, 8'h81);
    wr(P_EOI, 8'h00);
    rd(P_PEND, d); chk("t4_pend_clr", d, 8'h00);

    // 5: mask cleared during ASSERT does not revoke grant
    apply_reset();
    wr(P_MASK, 8'h0F);
    pulse(4'b1000);
    wait_irq("t5_irq", 10);
    wr(P_MASK, 8'h00);
    chk("t5_irq_held", 8'(bus.interrupt), 8'h01);
    step(); step(); step();
    chk("t5_irq_held2", 8'(bus.interrupt), 8'h01);
    ack();
    chk("t5_irq_ack", 8'(bus.interrupt), 8'h00);
    rd(P_STAT, d); chk("t5_stat", d, 8'h83);
    wr(P_EOI, 8'h00);
    rd(P_PEND, d); chk("t5_pend_clr", d, 8'h00);

    // 6: asynchronous reset mid-service
    apply_reset();
    wr(P_MASK, 8'h0F);
    pulse(4'b0101);
    wait_irq("t6_irq", 10);
    ack();
    bus.port_id = P_STAT;
    step();
    chk("t6_pre_hit", 8'(bus.rd_hit), 8'h01);
    chk("t6_pre_stat", bus.rd_data, 8'h80);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_irq", 8'(bus.interrupt), 8'h00);
    chk("t6_rst_hit", 8'(bus.rd_hit), 8'h00);
    chk("t6_rst_data", bus.rd_data, 8'h00);
    chk("t6_rst_pend", 8'(dut.r_pending), 8'h00);
    chk("t6_rst_mask", 8'(dut.r_mask), 8'h00);
    chk("t6_rst_valid", 8'(dut.r_active_valid), 8'h00);
    idle_bus();
    step(); step();
    reset_n = 1'b1;
    step();
    wr(P_EOI, 8'h00);
    rd(P_STAT, d); chk("t6_stray_eoi_stat", d, 8'h00);
    rd(P_PEND, d); chk("t6_stray_eoi_pend", d, 8'h00);
    chk("t6_no_irq", 8'(bus.interrupt), 8'h00);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/picoblaze_interrupt_controller.md
Name: picoblaze_interrupt_controller

Overview:
- Shares the single pacoblaze3 interrupt input between up to 8 event sources, such as the 1 Hz tick, timers and UART flags.
- Latches source pulses as pending bits, masks them, and picks one source round-robin.
- Drives `interrupt` and retires it on `interrupt_ack`.
- Holds the serviced source as "active" until firmware writes end-of-interrupt (EOI) through the output-port bus.
- Sits between the event generators and the processor; its read data joins the registered `in_port` mux.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..8).
- PORT_ID_STAT, 8'h01, read port: {active_valid, 4'b0, active_id[2:0]}.
- PORT_ID_PEND, 8'h02, read port: pending bits, zero-extended to 8.
- PORT_ID_MASK, 8'h40, write port: enable mask, low NUM_SRC bits used.
- PORT_ID_EOI, 8'h41, write port: end-of-interrupt; data is ignored.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- src_event, in, NUM_SRC, one-cycle clock-enable pulses, synchronous to clk.
- port_id, in, 8, processor port address.
- write_strobe, in, 1, processor write qualifier.
- read_strobe, in, 1, processor read qualifier (for status only; reads have no side effects).
- out_port, in, 8, processor write data.
- interrupt_ack, in, 1, processor acknowledge pulse, synchronous to clk.
- interrupt, out, 1, registered interrupt request to the processor.
- rd_data, out, 8, registered read data for the `in_port` mux.
- rd_hit, out, 1, registered; rd_data is valid for the current port_id.

Behaviour:
- Reset, asynchronous on reset_n low:
  - pending=0, mask=0, rr_ptr=0, active_id=0, active_valid=0.
  - interrupt=0, rd_data=0, rd_hit=0, state=IDLE.
  - Reset mid-service abandons the grant; no EOI is required afterwards.
- Pending register:
  - pending[i] sets on the edge where src_event[i]=1.
  - It clears only via EOI when active_id==i.
  - Set wins over a simultaneous EOI clear, so a new event is not lost.
  - Masked sources still latch pending.
- Eligibility: eligible = pending & mask.
- Arbitration: round-robin search from rr_ptr upward, wrapping at NUM_SRC-1 to 0.
- State machine:
  - IDLE: if eligible!=0, latch grant_id, then go to ASSERT; interrupt=1 from that edge.
    - Latency: event pulse at edge N, pending at N+1, interrupt high at N+2, provided mask is set and state is IDLE.
  - ASSERT: interrupt held at 1.
    - On interrupt_ack, interrupt=0, active_id=grant_id, active_valid=1, go to SERVICE.
    - Mask changes here do not revoke the grant.
  - SERVICE: no new interrupt; one source is serviced at a time.
    - On an EOI write, clear pending[active_id] (subject to set-wins), active_valid=0, rr_ptr=(active_id+1) mod NUM_SRC, go to IDLE.
    - A new eligible source can raise interrupt 1 cycle after EOI.
- EOI outside SERVICE is ignored.
- Mask write: mask <= out_port[NUM_SRC-1:0] on write_strobe && port_id==PORT_ID_MASK. It takes effect on the next cycle's eligibility.
- Read data is pipelined one cycle, like the existing `in_port` mux:
  - Every edge: rd_hit <= (port_id==STAT || port_id==PEND); rd_data <= selected value.
  - rd_data=0 when not hit.
- Port decode is full 8-bit equality; other port_ids are ignored.
- Widths: ID_W=3 fixed. rr_ptr wrap uses explicit compare with NUM_SRC-1, not natural overflow, so non-power-of-2 NUM_SRC works.

Decomposition:
- Shared package `picoblaze_io_pkg` holds:
  - the state enum (IDLE, ASSERT, SERVICE);
  - the default port-ID constants;
  - ID_W=3 and the max-sources constant 8.
- One sub-module: `rr_arbiter` (inputs: request vector, pointer; outputs: grant_id and any_grant). It is purely combinational and parameterised by NUM_SRC.

Test Plan:
1. Reset, mask=4'hF, pulse src_event=4'b0100 at edge N -> pending=4'b0100 at N+1, interrupt=1 at N+2; ack -> STAT read gives 8'h82; EOI -> pending=0, STAT read gives 8'h00.
2. mask=4'hF, pulse src_event=4'b1011 in one cycle -> serviced order 0,1,3 over successive ack/EOI cycles; rr_ptr ends at 0.
3. mask=4'b0001, pulse src 2 -> no interrupt, PEND read gives 8'h04; then write mask=4'h4 -> interrupt rises 1 cycle after the mask write.
4. In SERVICE with active_id=1, pulse src 1 on the same edge as EOI -> pending[1] stays 1, interrupt re-asserts after IDLE, and source 1 is serviced again.
5. In ASSERT, write mask=0 -> interrupt stays 1 until ack; active_id equals the original grant.
6. Drop reset_n low during SERVICE -> interrupt, pending, mask and active_valid are all 0 immediately, with no clock edge needed; a stray EOI after reset is ignored.
